// File: rtl/writeback_sequencer.sv
// Writeback sequencer: merges ALU and load results onto the single register-file write port.
// Optional WB_BYPASS_EN: idle ALU results are written combinationally in the same cycle.
module writeback_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  input  logic [3:0]                  alu_rd,
  input  logic [DATA_WIDTH-1:0]       alu_data,
  output logic                        alu_ready,
  input  logic                        mem_valid,
  input  logic [3:0]                  mem_rd,
  input  logic [DATA_WIDTH-1:0]       mem_data,
  output logic                        WE,
  output logic [3:0]                  destination_register,
  output logic [DATA_WIDTH-1:0]       WD,
  output logic                        pc_we,
  output logic [DATA_WIDTH-1:0]       pc_target,
  output logic [14:0]                 pending_mask,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] PC_IDX = 4'd15;

  typedef struct packed {
    logic [3:0]            rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  wb_req_t               fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  out_we_q, out_we_d, out_pc_we_q, out_pc_we_d;
  logic [3:0]            out_rd_q, out_rd_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d, out_pc_q, out_pc_d;

  wb_req_t issue_req;
  logic    issue_valid, push, pop, alu_accept, byp;

  // Ready comes from the registered count only, so a full FIFO refuses even while popping.
  assign alu_ready  = (count_q < CW'(FIFO_DEPTH)) & ~reset;
  assign alu_accept = alu_valid & alu_ready;
  assign fifo_count = count_q;

`ifdef WB_BYPASS_EN
  // Bypass only while the registered stage is idle, otherwise the two would collide on the port.
  assign byp = alu_accept & ~mem_valid & (count_q == '0) & ~out_we_q & ~out_pc_we_q;
`else
  assign byp = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    issue_valid = 1'b0;
    issue_req   = '{rd: alu_rd, data: alu_data};
    push        = 1'b0;
    pop         = 1'b0;
    if (mem_valid) begin
      issue_valid = 1'b1;
      issue_req   = '{rd: mem_rd, data: mem_data};
      push        = alu_accept;
    end else if (count_q != '0) begin
      issue_valid = 1'b1;
      issue_req   = fifo_q[rd_ptr_q];
      pop         = 1'b1;
      push        = alu_accept;
    end else if (alu_accept) begin
      issue_valid = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    out_we_d    = issue_valid & ~byp & (issue_req.rd != PC_IDX);
    out_pc_we_d = issue_valid & ~byp & (issue_req.rd == PC_IDX);
    out_rd_d    = out_we_d    ? issue_req.rd   : out_rd_q;
    out_data_d  = out_we_d    ? issue_req.data : out_data_q;
    out_pc_d    = out_pc_we_d ? issue_req.data : out_pc_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_we_q    <= 1'b0;
      out_pc_we_q <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
      out_pc_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_we_q    <= out_we_d;
      out_pc_we_q <= out_pc_we_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
      out_pc_q    <= out_pc_d;
    end
  end

  // NOTE: FIFO storage is not reset; an entry is only meaningful while count_q covers it.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{rd: alu_rd, data: alu_data};
  end

  always_comb begin
    WE                   = out_we_q;
    destination_register = out_rd_q;
    WD                   = out_data_q;
    pc_we                = out_pc_we_q;
    pc_target            = out_pc_q;
    if (byp) begin
      if (alu_rd == PC_IDX) begin
        pc_we     = 1'b1;
        pc_target = alu_data;
      end else begin
        WE                   = 1'b1;
        destination_register = alu_rd;
        WD                   = alu_data;
      end
    end
  end

  // Slot i holds a live entry when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] slot_off;
    pending_mask = '0;
    slot_off     = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_off = PW'(i) - rd_ptr_q;
      if (({1'b0, slot_off} < count_q) && (fifo_q[i].rd != PC_IDX))
        pending_mask[fifo_q[i].rd] = 1'b1;
    end
    if (out_we_q) pending_mask[out_rd_q] = 1'b1;
  end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Scoreboard bench for writeback_sequencer: a reference model predicts each issued write,
// FIFO occupancy and pending mask, and every cycle is compared against the DUT.
module tb_writeback_sequencer;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  typedef struct packed {
    logic [3:0]    rd;
    logic [DW-1:0] data;
  } req_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, mem_valid;
  logic [3:0]    alu_rd, mem_rd;
  logic [DW-1:0] alu_data, mem_data;
  logic          alu_ready, WE, pc_we;
  logic [3:0]    destination_register;
  logic [DW-1:0] WD, pc_target;
  logic [14:0]   pending_mask;
  logic [2:0]    fifo_count;

  int errors = 0;
  int checks = 0;

  req_t mq[$];  // model of the ALU FIFO contents
  req_t sb[$];  // expected writes, pushed at drive, popped when the DUT writes

  writeback_sequencer #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .WE(WE), .destination_register(destination_register), .WD(WD),
    .pc_we(pc_we), .pc_target(pc_target),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] model_mask(input bit has, input req_t iss);
    logic [14:0] m = '0;
    foreach (mq[i]) if (mq[i].rd != 4'd15) m[mq[i].rd] = 1'b1;
    if (has && iss.rd != 4'd15) m[iss.rd] = 1'b1;
    return m;
  endfunction

  task automatic step(input string tag, input bit av, input logic [3:0] ar, input logic [DW-1:0] ad,
                      input bit mv, input logic [3:0] mr, input logic [DW-1:0] md);
    req_t        iss = '0;
    req_t        exp;
    bit          has = 0;
    bit          acc;
    logic        exp_rdy;
    logic [14:0] exp_mask;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    #1;
    exp_rdy = (mq.size() < DEPTH);
    checks++;
    if (alu_ready !== exp_rdy) begin
      errors++;
      $display("FAIL %s.ready: got %b, want %b", tag, alu_ready, exp_rdy);
    end
    acc = av && exp_rdy;
    if (mv) begin
      iss = '{rd: mr, data: md}; has = 1;
      if (acc) mq.push_back('{rd: ar, data: ad});
    end else if (mq.size() > 0) begin
      iss = mq.pop_front(); has = 1;
      if (acc) mq.push_back('{rd: ar, data: ad});
    end else if (acc) begin
      iss = '{rd: ar, data: ad}; has = 1;
    end
    if (has) sb.push_back(iss);
    exp_mask = model_mask(has, iss);
    @(posedge clk); #1;
    checks++;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      if (exp.rd == 4'd15) begin
        if ({WE, pc_we} !== 2'b01 || pc_target !== exp.data) begin
          errors++;
          $display("FAIL %s.pcwrite: got WE=%b pc_we=%b pc_target=%h, want WE=0 pc_we=1 pc_target=%h",
                   tag, WE, pc_we, pc_target, exp.data);
        end
      end else if ({WE, pc_we} !== 2'b10 || destination_register !== exp.rd || WD !== exp.data) begin
        errors++;
        $display("FAIL %s.write: got WE=%b pc_we=%b rd=%0d WD=%h, want WE=1 pc_we=0 rd=%0d WD=%h",
                 tag, WE, pc_we, destination_register, WD, exp.rd, exp.data);
      end
    end else if ({WE, pc_we} !== 2'b00) begin
      errors++;
      $display("FAIL %s.idle: got WE=%b pc_we=%b, want both 0", tag, WE, pc_we);
    end
    checks++;
    if (fifo_count !== 3'(mq.size())) begin
      errors++;
      $display("FAIL %s.count: got %0d, want %0d", tag, fifo_count, mq.size());
    end
    checks++;
    if (pending_mask !== exp_mask) begin
      errors++;
      $display("FAIL %s.pending: got %h, want %h", tag, pending_mask, exp_mask);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 4'd0, '0, 0, 4'd0, '0);
  endtask

  task automatic test_reset;
    reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
    #2 reset = 1'b1;
    #6;
    checks++;
    if ({WE, pc_we, alu_ready} !== 3'b000 || destination_register !== 4'd0 || WD !== '0 ||
        pc_target !== '0 || pending_mask !== '0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL reset.state: got WE=%b pc_we=%b rdy=%b rd=%0d WD=%h pc=%h mask=%h cnt=%0d, want all 0",
               WE, pc_we, alu_ready, destination_register, WD, pc_target, pending_mask, fifo_count);
    end
    #4 reset = 1'b0;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset.ready_after: got %b, want 1", alu_ready);
    end
  endtask

  task automatic test_single_alu;
    step("single", 1, 4'd3, 32'hDEADBEEF, 0, 4'd0, '0);
    idle("single_after", 1);
  endtask

  task automatic test_mem_priority;
    step("prio", 1, 4'd1, 32'h11, 1, 4'd2, 32'h22);
    idle("prio_drain", 2);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++)
      step("b2b_mem", 1, 4'(i + 4), 32'h100 + i, 1, 4'd0, 32'hA0 + i);
    // Full FIFO with no load: head pops but the offered ALU result is refused.
    step("b2b_full", 1, 4'd13, 32'hFFF, 0, 4'd0, '0);
    idle("b2b_drain", 5);
  endtask

  task automatic test_pc_write;
    step("pc_alu", 1, 4'd15, 32'h00000100, 0, 4'd0, '0);
    step("pc_mem", 0, 4'd0, '0, 1, 4'd15, 32'h0000_2000);
    idle("pc_after", 1);
  endtask

  task automatic test_reset_midop;
    for (int i = 0; i < 3; i++)
      step("mid_fill", 1, 4'(i + 1), 32'hC0 + i, 1, 4'd9, 32'hB0 + i);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({WE, pc_we, alu_ready} !== 3'b000 || pending_mask !== '0 || fifo_count !== '0 ||
        destination_register !== 4'd0 || WD !== '0) begin
      errors++;
      $display("FAIL mid.reset: got WE=%b pc_we=%b rdy=%b mask=%h cnt=%0d rd=%0d WD=%h, want all 0",
               WE, pc_we, alu_ready, pending_mask, fifo_count, destination_register, WD);
    end
    @(posedge clk); #2 reset = 1'b0;
    mq.delete();
    sb.delete();
    idle("mid_after", 4);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++)
      step("rand", bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), $urandom);
    idle("rand_drain", 6);
  endtask

  task automatic test_bypass;
    #1;
    alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 32'd7;
    #1;
    checks++;
    if (WE !== 1'b1 || destination_register !== 4'd5 || WD !== 32'd7 || pc_we !== 1'b0 ||
        pending_mask !== '0) begin
      errors++;
      $display("FAIL bypass.same_cycle: got WE=%b rd=%0d WD=%h pc_we=%b mask=%h, want 1 5 7 0 0",
               WE, destination_register, WD, pc_we, pending_mask);
    end
    @(posedge clk); #1;
    alu_valid = 1'b0;
    #1;
    checks++;
    if ({WE, pc_we} !== 2'b00 || fifo_count !== '0) begin
      errors++;
      $display("FAIL bypass.next: got WE=%b pc_we=%b cnt=%0d, want 0 0 0", WE, pc_we, fifo_count);
    end
  endtask

  initial begin
    test_reset;
`ifdef WB_BYPASS_EN
    test_bypass;
`else
    test_single_alu;
    test_mem_priority;
    test_back_to_back;
    test_pc_write;
    test_reset_midop;
    test_random;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
